// File: rtl/display_bcd_feeder.sv
// Samples a 16-bit binary value and converts it to four packed BCD digits with
// shift-add-3, one bit per cycle; saturates to 9999 with ovf when out of range.
module display_bcd_feeder #(
   parameter int unsigned SAMPLE_PERIOD = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        start,
   input  logic        auto_en,
   output logic [15:0] bcd_out,
   output logic        ovf,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
   localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] per_cnt;
   logic          auto_tc;
   logic          req;
   logic          pend, pend_nxt;
   logic [3:0]    iter, iter_nxt;
   logic [15:0]   sreg, sreg_nxt;
   logic [19:0]   scratch, scratch_nxt;
   logic [19:0]   adj;
   logic [20:0]   shifted;
   logic [15:0]   bcd_nxt;
   logic          ovf_nxt;
   logic          busy_nxt;
   logic          done_nxt;

   function automatic logic [19:0] add3(input logic [19:0] s);
      logic [19:0] r;
      r = s;
      for (int d = 0; d < 5; d++) begin
         if (s[4*d +: 4] >= 4'd5)
            r[4*d +: 4] = s[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign auto_tc = auto_en && (per_cnt == PER_LAST);
   assign req     = start || auto_tc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         per_cnt <= '0;
      else if (!auto_en || auto_tc)
         per_cnt <= '0;
      else
         per_cnt <= per_cnt + 1'b1;
   end

   // Bit 20 can only be set by an out-of-range value, so it folds into the overflow test.
   assign adj     = add3(scratch);
   assign shifted = {adj, sreg[15]};

   always_comb begin
      state_nxt   = state;
      pend_nxt    = pend;
      iter_nxt    = iter;
      sreg_nxt    = sreg;
      scratch_nxt = scratch;
      bcd_nxt     = bcd_out;
      ovf_nxt     = ovf;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (req || pend) begin
               state_nxt   = SHIFT;
               sreg_nxt    = value;
               scratch_nxt = '0;
               pend_nxt    = 1'b0;
               iter_nxt    = '0;
               busy_nxt    = 1'b1;
            end
         end
         SHIFT: begin
            scratch_nxt = shifted[19:0];
            sreg_nxt    = {sreg[14:0], 1'b0};
            iter_nxt    = iter + 4'd1;
            if (req)
               pend_nxt = 1'b1;
            if (iter == 4'd15) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               if (|shifted[20:16]) begin
                  bcd_nxt = 16'h9999;
                  ovf_nxt = 1'b1;
               end else begin
                  bcd_nxt = shifted[15:0];
                  ovf_nxt = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pend    <= 1'b0;
         iter    <= '0;
         sreg    <= '0;
         scratch <= '0;
         bcd_out <= '0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pend    <= pend_nxt;
         iter    <= iter_nxt;
         sreg    <= sreg_nxt;
         scratch <= scratch_nxt;
         bcd_out <= bcd_nxt;
         ovf     <= ovf_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_display_bcd_feeder.sv
// Scoreboard bench for display_bcd_feeder: stimulus queues expected results,
// a negedge monitor pops one per done pulse.
module tb_display_bcd_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] value = '0;
   logic        start = 1'b0;
   logic        auto_en = 1'b0;
   logic [15:0] bcd_out;
   logic        ovf;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   int          done_count = 0;
   int          done_t[$];
   logic [16:0] exp_q[$];
   logic [16:0] e;

   display_bcd_feeder #(.SAMPLE_PERIOD(20)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .value   (value),
      .start   (start),
      .auto_en (auto_en),
      .bcd_out (bcd_out),
      .ovf     (ovf),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int req_v);
      checks++;
      if (act == req_v)
         passes++;
      else
         $display("FAIL %s: got %0h, required %0h", name, act, req_v);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_count++;
         done_t.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done with bcd_out=%0h, required no result", bcd_out);
         end else begin
            e = exp_q.pop_front();
            chk("result_bcd", int'(bcd_out), int'(e[16:1]));
            chk("result_ovf", int'(ovf), int'(e[0]));
         end
      end
   end

   task automatic pulse(input logic [15:0] v);
      @(negedge clk);
      value = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_dones(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_count >= target) break;
         @(negedge clk);
         #1;
      end
      if (done_count < target) begin
         checks++;
         $display("FAIL wait_done_timeout: got %0d dones, required %0d", done_count, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      bit hold_ok;
      logic [15:0] vals[4];
      logic [16:0] exps[4];
      vals[0] = 16'd0;     exps[0] = {16'h0000, 1'b0};
      vals[1] = 16'd9999;  exps[1] = {16'h9999, 1'b0};
      vals[2] = 16'd10000; exps[2] = {16'h9999, 1'b1};
      vals[3] = 16'd65535; exps[3] = {16'h9999, 1'b1};

      #2 rst_n = 1'b0;
      #3;
      chk("rst_bcd", int'(bcd_out), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single conversion with latency check
      exp_q.push_back({16'h1234, 1'b0});
      pulse(16'd1234);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 16);
      chk("done_after_busy", int'(done), 1);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);

      // Range boundaries
      for (int k = 0; k < 4; k++) begin
         base = done_count;
         exp_q.push_back(exps[k]);
         pulse(vals[k]);
         wait_dones(base + 1, 40);
      end

      // Value sampled at accept; two requests while busy collapse into one
      base = done_count;
      exp_q.push_back({16'h0042, 1'b0});
      exp_q.push_back({16'h0007, 1'b0});
      pulse(16'd42);
      @(negedge clk);
      value = 16'd7;
      pulse(16'd7);
      @(negedge clk);
      pulse(16'd7);
      wait_dones(base + 2, 80);
      if (done_count >= base + 2)
         chk("pending_interval", done_t[base + 1] - done_t[base], 17);
      repeat (40) @(negedge clk);
      chk("pending_done_count", done_count - base, 2);

      // Auto mode
      base = done_count;
      repeat (3) exp_q.push_back({16'h0500, 1'b0});
      @(negedge clk);
      value = 16'd500;
      auto_en = 1'b1;
      wait_dones(base + 3, 120);
      auto_en = 1'b0;
      if (done_count >= base + 3) begin
         chk("auto_interval_1", done_t[base + 1] - done_t[base], 20);
         chk("auto_interval_2", done_t[base + 2] - done_t[base + 1], 20);
      end
      repeat (60) @(negedge clk);
      chk("auto_off_count", done_count - base, 3);
      chk("auto_off_hold", int'(bcd_out), 16'h0500);

      // Reset mid-conversion
      base = done_count;
      exp_q.push_back({16'h8888, 1'b0});
      pulse(16'd8888);
      wait_dones(base + 1, 40);
      pulse(16'd1111);
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_bcd", int'(bcd_out), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_ovf", int'(ovf), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("midrst_no_result", done_count - base, 1);
      exp_q.push_back({16'h1111, 1'b0});
      pulse(16'd1111);
      wait_dones(base + 2, 40);

      // Continuous start: one result per 17 cycles
      base = done_count;
      repeat (4) exp_q.push_back({16'h0321, 1'b0});
      @(negedge clk);
      value = 16'd321;
      start = 1'b1;
      wait_dones(base + 1, 40);
      hold_ok = 1'b1;
      for (int i = 0; i < 120 && done_count < base + 4; i++) begin
         @(negedge clk);
         #1;
         if (bcd_out != 16'h0321) hold_ok = 1'b0;
         if (done_count >= base + 3) start = 1'b0;
      end
      start = 1'b0;
      chk("hold_stable", int'(hold_ok), 1);
      if (done_count >= base + 4) begin
         chk("hold_interval_1", done_t[base + 1] - done_t[base], 17);
         chk("hold_interval_2", done_t[base + 2] - done_t[base + 1], 17);
         chk("hold_interval_3", done_t[base + 3] - done_t[base + 2], 17);
      end
      repeat (40) @(negedge clk);
      chk("hold_done_count", done_count - base, 4);
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/display_bcd_feeder.md
# display_bcd_feeder

Upstream feeder for the four-digit seven-segment display driver. It samples a 16-bit binary value, converts it iteratively (shift-add-3) into four packed BCD digits, and holds the result steady on `bcd_out`, which drives the display driver's `num` input. A conversion starts on an explicit request or periodically in auto mode, so that values produced by the CPU can be shown in decimal without flicker.

## Interface
- `SAMPLE_PERIOD`, default 1000000: auto-mode sampling interval in `clk` cycles; minimum 18.
- `clk`  in  1  system clock; one clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  16  unsigned binary value to convert.
- `start`  in  1  conversion request, level-sampled on each rising edge.
- `auto_en`  in  1  enables periodic conversion requests.
- `bcd_out`  out  16  packed BCD, digit 3 in `[15:12]` down to digit 0 in `[3:0]`; connects to the display `num` input.
- `ovf`  out  1  last result exceeded 9999.
- `busy`  out  1  a conversion is in progress.
- `done`  out  1  one-cycle pulse: `bcd_out` and `ovf` were just updated.

## Operation
- **States**
  - IDLE: waiting for a request.
  - SHIFT: runs exactly 16 iterations, tracked by a 4-bit iteration counter.
- **Request sources**
  - `start` = 1 on an edge.
  - Auto terminal count: while `auto_en` = 1, a period counter runs 0..`SAMPLE_PERIOD`-1 and wraps. Reaching `SAMPLE_PERIOD`-1 raises one request.
  - While `auto_en` = 0, the period counter is held at 0.
- **Pending flag**
  - One-deep. It is set by any request that arrives while in SHIFT.
  - Multiple requests during one conversion collapse into a single pending request.
- **Accept**
  - In IDLE, a request or a set pending flag moves the FSM to SHIFT.
  - On that edge: `value` is captured into a 16-bit shift register, the 20-bit BCD scratch is cleared, and pending is cleared.
  - `value` is sampled at accept time, not at request time.
- **Iteration** (one per cycle in SHIFT)
  - Each of the 5 scratch digits that is ≥5 has 3 added to it.
  - The scratch and the shift register are then shifted left by one as a single unit. The MSB of the shift register enters the scratch LSB.
- **Completion** (on the edge of the 16th iteration)
  - The final scratch value is computed combinationally and written directly to the outputs.
  - If scratch digit 4 is nonzero: `bcd_out` = 16'h9999 and `ovf` = 1.
  - Otherwise: `bcd_out` = scratch[15:0] and `ovf` = 0.
  - `done` = 1 for one cycle and the FSM returns to IDLE.
- **Output hold**
  - `bcd_out` and `ovf` change only on the completion edge.
  - They hold the previous result throughout a conversion.
- **Reset**
  - Asynchronous. Applies at any time, including mid-conversion; the partial result is discarded.
  - Reset values: FSM = IDLE; `bcd_out`, `ovf`, `busy`, `done`, pending flag, period counter and iteration counter all = 0.

## Timing
- **Latency**
  - Let E be the accept edge. `busy` = 1 from E to E+16.
  - Iterations occur at edges E+1 through E+16.
  - `bcd_out`, `ovf` and `done` are valid in the cycle after edge E+16; `busy` = 0 in that same cycle.
  - Total: 16 cycles from accept to result.
- **Back-to-back**
  - If pending is set, the next accept happens at edge E+17 (the first IDLE cycle).
  - Maximum throughput is one result per 17 cycles.
- **Simultaneous events**
  - `start` and an auto terminal count on the same edge count as one request.
  - A request on the completion edge sets pending.
  - A request on the accept edge is absorbed by that accept.
- **`auto_en` transitions**
  - Falling: zeroes the counter on the next edge and does not cancel a conversion in flight or a pending request.
  - Rising: the counter starts from 0; the first auto request comes `SAMPLE_PERIOD` cycles later.
- All outputs are registered; no combinational path exists from input to output.

## Test plan
- `value` = 1234 with a 1-cycle `start` pulse → `busy` high for 16 cycles; next cycle `bcd_out` = 16'h1234, `ovf` = 0, `done` pulses once.
- `value` = 0, then 9999, then 10000, then 65535 → `bcd_out` = 16'h0000/0, 16'h9999/0, 16'h9999/1, 16'h9999/1 (`bcd_out`/`ovf`).
- Convert 42, then change `value` to 7 mid-conversion and pulse `start` twice during busy → first result 16'h0042. Exactly one follow-up conversion is accepted at E+17 with `value` = 7, giving 16'h0007 and two `done` pulses in total.
- `SAMPLE_PERIOD` = 20, `auto_en` = 1, `value` = 500 → `done` every 20 cycles with `bcd_out` = 16'h0500. Drop `auto_en` → no further `done`, and `bcd_out` holds 16'h0500.
- Convert 8888, then start converting 1111 and assert `rst_n` = 0 at iteration 8 → `bcd_out` = 0, `busy` = 0 and `done` = 0 immediately. After release, no result appears until a new `start`.
- Hold `start` = 1 continuously with `value` = 321 → `done` every 17 cycles; `bcd_out` stays 16'h0321 with no intermediate values.
